// File: rtl/mcpu_core_pkg.sv
// Shared definitions for the MCPU interrupt controller: line count, mask width, FSM state encoding.
package mcpu_core_pkg;

    localparam int NUM_INT    = 4;
    localparam int INT_TYPE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } intctl_state_e;

endpackage

// File: rtl/mcpu_core_int_edge.sv
// Per-line conditioning and rising-edge detector for one external interrupt line.
// Define MCPU_INTCTL_SYNC_EN to insert a 2-flop synchronizer ahead of the edge detector.
module mcpu_core_int_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic rise_o
);

    logic cond;
    logic prev_q;

`ifdef MCPU_INTCTL_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
        end
    end

    assign cond = sync2_q;
`else
    assign cond = line_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= cond;
        end
    end

    assign rise_o = cond & ~prev_q;

endmodule

// File: rtl/mcpu_core_intctl.sv
// Interrupt controller: latches external interrupt edges, arms the pipeline request when enabled,
// and suppresses delivery for HOLDOFF_CYCLES after exception entry or eret.
//
// state      | meaning
// ST_IDLE    | nothing deliverable (no pending lines or interrupts disabled)
// ST_ARMED   | int_pending asserted, int_type shows the lines being delivered
// ST_HOLDOFF | counting down after exception/eret; edges still latch
module mcpu_core_intctl
    import mcpu_core_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic                  clkrst_core_clk,
    input  logic                  clkrst_core_rst,
    input  logic [NUM_INT-1:0]    ext_int_in,
    input  logic                  interrupts_enabled,
    input  logic                  exception,
    input  logic                  eret_taken,
    output logic                  int_pending,
    output logic [INT_TYPE_W-1:0] int_type,
    output logic [NUM_INT-1:0]    pending_vec
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES);

    intctl_state_e     state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_INT-1:0] pend_q;
    logic [NUM_INT-1:0] pend_d;
    logic [NUM_INT-1:0] rise;

    for (genvar i = 0; i < NUM_INT; i++) begin : g_edge
        mcpu_core_int_edge u_edge (
            .clk_i  (clkrst_core_clk),
            .rst_i  (clkrst_core_rst),
            .line_i (ext_int_in[i]),
            .rise_o (rise[i])
        );
    end

    assign int_pending = (state_q == ST_ARMED);
    assign int_type    = (state_q == ST_ARMED) ? pend_q : '0;
    assign pending_vec = pend_q;

    // A fresh edge wins over the capture-clear of the same line.
    always_comb begin
        pend_d = pend_q;
        if (exception) begin
            pend_d = pend_q & ~int_type;
        end
        pend_d = pend_d | rise;
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            pend_q <= pend_d;
            if (exception || eret_taken) begin
                state_q <= ST_HOLDOFF;
                cnt_q   <= HOLDOFF_LOAD;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if ((pend_q != '0) && interrupts_enabled) begin
                            state_q <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (!interrupts_enabled) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_HOLDOFF: begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcpu_core_intctl.sv
// Directed vector bench for mcpu_core_intctl (HOLDOFF_CYCLES=2).
module tb_mcpu_core_intctl;

    logic       clk;
    logic       rst;
    logic [3:0] ext;
    logic       en;
    logic       exc;
    logic       eret;
    logic       ip;
    logic [3:0] ityp;
    logic [3:0] pvec;

    int n_tests = 0;
    int n_fail  = 0;

    mcpu_core_intctl #(.HOLDOFF_CYCLES(2)) dut (
        .clkrst_core_clk    (clk),
        .clkrst_core_rst    (rst),
        .ext_int_in         (ext),
        .interrupts_enabled (en),
        .exception          (exc),
        .eret_taken         (eret),
        .int_pending        (ip),
        .int_type           (ityp),
        .pending_vec        (pvec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] ext;
        logic       en;
        logic       exc;
        logic       eret;
        logic [3:0] pend;
        logic       ip;
        logic [3:0] ty;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic [3:0] e, logic n, logic x, logic t,
                                logic [3:0] p, logic i, logic [3:0] y);
        vec_t v;
        v.rst = r; v.ext = e; v.en = n; v.exc = x; v.eret = t;
        v.pend = p; v.ip = i; v.ty = y;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

`ifdef MCPU_INTCTL_SYNC_EN
    localparam int EDGE_LAT = 3;
`else
    localparam int EDGE_LAT = 1;
`endif

    initial begin
        int cnt;
        rst = 1'b1; ext = '0; en = 1'b0; exc = 1'b0; eret = 1'b0;

        //            rst ext      en   exc  eret pend     ip   ty
        vq.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000)); // 0 reset
        vq.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0000));
        vq.push_back(mk(0, 4'b0100, 1, 0, 0, 4'b0100, 0, 4'b0000)); // 2 edge line 2
        vq.push_back(mk(0, 4'b0100, 1, 0, 0, 4'b0100, 1, 4'b0100)); // armed
        vq.push_back(mk(0, 4'b0000, 1, 1, 0, 4'b0000, 0, 4'b0000)); // capture
        vq.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0000));
        vq.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0000)); // 6 idle
        vq.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 0, 4'b0000)); // disabled edge
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0001, 0, 4'b0000));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0001, 0, 4'b0000));
        vq.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0001, 1, 4'b0001)); // 10 enable -> armed
        vq.push_back(mk(0, 4'b0010, 1, 0, 0, 4'b0011, 1, 4'b0011));
        vq.push_back(mk(0, 4'b0010, 1, 1, 0, 4'b0000, 0, 4'b0000)); // capture 0011
        vq.push_back(mk(0, 4'b0010, 1, 0, 0, 4'b0000, 0, 4'b0000));
        vq.push_back(mk(0, 4'b0010, 1, 0, 0, 4'b0000, 0, 4'b0000));
        vq.push_back(mk(0, 4'b0010, 1, 0, 0, 4'b0000, 0, 4'b0000)); // 15
        vq.push_back(mk(0, 4'b0011, 1, 0, 0, 4'b0001, 0, 4'b0000));
        vq.push_back(mk(0, 4'b0010, 1, 0, 0, 4'b0001, 1, 4'b0001));
        vq.push_back(mk(0, 4'b0011, 1, 1, 0, 4'b0001, 0, 4'b0000)); // set beats clear
        vq.push_back(mk(0, 4'b0011, 1, 0, 0, 4'b0001, 0, 4'b0000));
        vq.push_back(mk(0, 4'b0011, 1, 0, 0, 4'b0001, 0, 4'b0000)); // 20 idle
        vq.push_back(mk(0, 4'b0011, 1, 0, 0, 4'b0001, 1, 4'b0001)); // re-armed
        vq.push_back(mk(0, 4'b0011, 1, 1, 1, 4'b0000, 0, 4'b0000)); // exc + eret
        vq.push_back(mk(0, 4'b0111, 1, 0, 0, 4'b0100, 0, 4'b0000));
        vq.push_back(mk(0, 4'b0111, 1, 0, 0, 4'b0100, 0, 4'b0000));
        vq.push_back(mk(0, 4'b0111, 1, 0, 0, 4'b0100, 1, 4'b0100)); // 25
        vq.push_back(mk(0, 4'b0111, 1, 0, 1, 4'b0100, 0, 4'b0000)); // eret alone
        vq.push_back(mk(0, 4'b0111, 1, 0, 0, 4'b0100, 0, 4'b0000));
        vq.push_back(mk(0, 4'b0111, 1, 0, 0, 4'b0100, 0, 4'b0000));
        vq.push_back(mk(0, 4'b0111, 1, 0, 0, 4'b0100, 1, 4'b0100));
        vq.push_back(mk(0, 4'b0111, 0, 0, 0, 4'b0100, 0, 4'b0000)); // 30 disable
        vq.push_back(mk(0, 4'b0111, 0, 1, 0, 4'b0100, 0, 4'b0000)); // exc in idle
        vq.push_back(mk(0, 4'b0111, 1, 0, 0, 4'b0100, 0, 4'b0000));
        vq.push_back(mk(0, 4'b0111, 1, 0, 0, 4'b0100, 0, 4'b0000)); // holdoff exit
        vq.push_back(mk(0, 4'b0111, 1, 0, 0, 4'b0100, 1, 4'b0100));
        vq.push_back(mk(0, 4'b0011, 1, 0, 0, 4'b0100, 1, 4'b0100)); // 35
        vq.push_back(mk(0, 4'b0111, 1, 0, 0, 4'b0100, 1, 4'b0100)); // coalesce
        vq.push_back(mk(0, 4'b1111, 1, 1, 0, 4'b1000, 0, 4'b0000));
        vq.push_back(mk(1, 4'b1111, 1, 0, 0, 4'b0000, 0, 4'b0000)); // reset in holdoff
        vq.push_back(mk(0, 4'b1111, 1, 0, 0, 4'b1111, 0, 4'b0000)); // held-high lines
        vq.push_back(mk(0, 4'b1111, 1, 0, 0, 4'b1111, 1, 4'b1111)); // 40

`ifndef MCPU_INTCTL_SYNC_EN
        foreach (vq[k]) begin
            rst = vq[k].rst; ext = vq[k].ext; en = vq[k].en;
            exc = vq[k].exc; eret = vq[k].eret;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pending_vec", k), pvec, vq[k].pend);
            chk($sformatf("v%0d int_pending", k), {3'b000, ip}, {3'b000, vq[k].ip});
            chk($sformatf("v%0d int_type", k), ityp, vq[k].ty);
        end
`endif

        // edge-to-pending latency on line 3, starting from a clean reset
        rst = 1'b1; ext = '0; en = 1'b0; exc = 1'b0; eret = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post-reset pending_vec", pvec, 4'b0000);
        chk("post-reset int_type", ityp, 4'b0000);
        ext = 4'b1000;
        cnt = 0;
        while (cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
            if (pvec[3]) break;
        end
        n_tests++;
        if (!pvec[3]) begin
            n_fail++;
            $display("FAIL line3 latency: pending_vec[3] never set within %0d cycles", cnt);
        end else if (cnt != EDGE_LAT) begin
            n_fail++;
            $display("FAIL line3 latency: got %0d cycles expected %0d", cnt, EDGE_LAT);
        end
        chk("line3 pending_vec", pvec, 4'b1000);
        chk("line3 int_pending disabled", {3'b000, ip}, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mcpu_core_intctl.md
MCPU_CORE_INTCTL -- requirements
Module: mcpu_core_intctl

Interface
REQ-001 Parameter: HOLDOFF_CYCLES, 2, cycles interrupts stay suppressed after exception entry or eret; legal range 1..15.
REQ-002 clkrst_core_clk  in  1  core clock; sole clock.
REQ-003 clkrst_core_rst  in  1  reset, synchronous, active-high.
REQ-004 ext_int_in  in  4  raw external interrupt lines; rising-edge sensitive.
REQ-005 interrupts_enabled  in  1  global enable from coprocessor status reg bit 0.
REQ-006 exception  in  1  pipeline takes an exception this cycle (any cause).
REQ-007 eret_taken  in  1  eret instruction retires this cycle.
REQ-008 int_pending  out  1  interrupt request to pipeline exception logic.
REQ-009 int_type  out  4  bitmask of interrupts being delivered; valid in the exception cycle.
REQ-010 pending_vec  out  4  latched pending interrupts, status/debug.

Function
REQ-011 Edge detect SHALL register the previous (conditioned) sample per line; a sample at 1 after a sample at 0 is a rising edge.
REQ-012 A rising edge SHALL set pending_vec[i] on the same clock edge that detects it.
REQ-013 FSM states SHALL be IDLE, ARMED and HOLDOFF.
REQ-014 IDLE->ARMED SHALL occur when pending_vec!=0 and interrupts_enabled=1.
REQ-015 ARMED->IDLE SHALL occur when interrupts_enabled=0 and exception=0.
REQ-016 int_pending SHALL equal (state==ARMED), decoded from registered state only.
REQ-017 int_type SHALL equal pending_vec when state==ARMED, else 4'b0, combinationally, so it is valid in the exception cycle.
REQ-018 On exception=1 in any state:
  - bits of pending_vec set in int_type SHALL be cleared;
  - FSM SHALL enter HOLDOFF;
  - holdoff counter SHALL load HOLDOFF_CYCLES.
REQ-019 On eret_taken=1 with exception=0: FSM SHALL enter HOLDOFF and reload the counter.
REQ-020 In HOLDOFF the counter SHALL decrement once per cycle; at counter==1 the next state SHALL be IDLE.
REQ-021 IDLE->ARMED SHALL not happen in the same cycle HOLDOFF exits.
REQ-022 Simultaneous exception and eret_taken: exception SHALL take priority.
REQ-023 Edge and capture-clear on the same bit in the same cycle: set wins, bit stays 1.
REQ-024 Interrupt edges during HOLDOFF or while disabled SHALL still latch into pending_vec; none are lost.
REQ-025 Repeated edges on an already-pending line SHALL coalesce into one pending bit.

Reset
REQ-026 Reset SHALL force state=IDLE, counter=0, pending_vec=0 and edge/sync registers=0, so int_pending=0 and int_type=0.
REQ-027 Reset asserted mid-HOLDOFF or mid-ARMED SHALL discard all pending interrupts.
REQ-028 A line held high through reset release SHALL register one edge on the first post-reset sample.

Configuration
REQ-029 With MCPU_INTCTL_SYNC_EN defined, each ext_int_in line SHALL pass through a 2-flop synchronizer before edge detect, adding 2 cycles of latency.
REQ-030 Without MCPU_INTCTL_SYNC_EN, ext_int_in is treated as synchronous to clkrst_core_clk and feeds edge detect directly.

Structure
REQ-031 Shared package mcpu_core_pkg SHALL hold:
  - FSM state enum;
  - NUM_INT=4;
  - INT_TYPE_W=4.
REQ-032 Per-line synchronizer and edge detector SHALL be sub-module mcpu_core_int_edge, instantiated 4 times.
REQ-033 mcpu_core_int_edge alone SHALL contain the MCPU_INTCTL_SYNC_EN conditional.

Verification
REQ-034 No sync: ext_int_in 0000->0100 at edge k, enabled -> pending_vec=0100 after k; int_pending=1 after k+1; int_type=0100.
REQ-035 Enabled=0, pulse line 0 -> pending_vec=0001, int_pending stays 0; raise enable -> int_pending=1 one cycle later.
REQ-036 ARMED with pending 0011, exception=1 -> int_type=0011 that cycle; pending_vec=0000 next; int_pending=0 for exactly 2 cycles; then IDLE.
REQ-037 Exception cycle with new edge on line 0 while capturing 0001 -> pending_vec stays 0001; re-ARMED after holdoff.
REQ-038 exception and eret_taken both 1 -> capture and clear occur as for exception; counter=HOLDOFF_CYCLES.
REQ-039 With MCPU_INTCTL_SYNC_EN, edge on line 3 -> pending_vec[3] sets 2 cycles later than REQ-034.
REQ-040 Reset pulse during HOLDOFF with pending 1000 -> all outputs 0 next cycle.
